// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmit path among NREQ requesters. A round-robin arbiter
// picks a requester while idle, latches its byte / parity / stop selects,
// gives the UART one cycle of stable configuration, fires a single trigger
// strobe and then waits for the rising edge of the UART's sended flag.
// The requester is told about completion (done) or a timeout (tmo_err), and
// a fixed idle gap is enforced before the next grant.
//
// State table
//   state | meaning
//   IDLE  | no frame in flight; arbitrate and grant on a pending request
//   SETUP | config/data latched and enable high; hold one cycle before trigger
//   FIRE  | issue the trigger strobe, clear the watchdog counter
//   WAIT  | watchdog counts; sended rising edge -> done, expiry -> tmo_err
//   GAPW  | inter-frame gap of GAP cycles, enable still high
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   req           in   [NREQ]   level requests, held until done/tmo_err
//   req_data      in   [8*NREQ] byte of requester i at [8i+7:8i]
//   req_odd       in   [NREQ]   parity select per requester
//   req_stop      in   [NREQ]   stop-bit select per requester
//   grant         out  [NREQ]   one-hot pulse when the winner's fields latch
//   done          out  [NREQ]   one-hot pulse when the frame completes
//   tmo_err       out  pulse when the watchdog expires (never with done)
//   busy          out  high in every state except IDLE
//   uart_enable   out  UART enable, SETUP through GAPW
//   uart_trigger  out  one-cycle send strobe
//   uart_odd      out  latched parity select
//   uart_stop     out  latched stop select
//   uart_tx_data  out  [8] latched byte
//   uart_sended   in   UART completion flag (rising edge used)
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 100000,
    parameter int GAP     = 16,
    parameter int CW      = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_odd,
    input  logic [NREQ-1:0]     req_stop,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                tmo_err,
    output logic                busy,
    output logic                uart_enable,
    output logic                uart_trigger,
    output logic                uart_odd,
    output logic                uart_stop,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_sended
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_FIRE  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAPW  = 3'd4;

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sended_q;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            tmo_q, tmo_d;
    logic            en_q, en_d;
    logic            trig_q, trig_d;
    logic            odd_q, odd_d;
    logic            stop_q, stop_d;
    logic [7:0]      data_q, data_d;

    logic            sended_rise;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    int              cand;
    logic [7:0]      win_data;
    logic            win_odd;
    logic            win_stop;

    assign sended_rise = uart_sended & ~sended_q;

    // Round-robin scan: start one past the last winner and wrap, so the most
    // recently served requester is always considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Field mux for the winner; constant-index slices keep the select clean.
    always_comb begin
        win_data = '0;
        win_odd  = 1'b0;
        win_stop = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_data = req_data[8*i +: 8];
                win_odd  = req_odd[i];
                win_stop = req_stop[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        odd_d        = odd_q;
        stop_d       = stop_q;
        en_d         = en_q;
        grant_d      = '0;
        done_d       = '0;
        tmo_d        = 1'b0;
        trig_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    cur_d        = win_idx;
                    last_grant_d = win_idx;
                    data_d       = win_data;
                    odd_d        = win_odd;
                    stop_d       = win_stop;
                    grant_d      = NREQ'(1) << win_idx;
                    en_d         = 1'b1;
                    state_d      = S_SETUP;
                end
            end

            S_SETUP: begin
                state_d = S_FIRE;
            end

            S_FIRE: begin
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Completion is checked first so a sended edge landing on the
                // last watchdog cycle still counts as a good frame.
                if (sended_rise) begin
                    done_d  = NREQ'(1) << cur_q;
                    cnt_d   = '0;
                    state_d = S_GAPW;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAPW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_GAPW: begin
                if (cnt_q == GAP_LAST) begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_grant_q <= IW'(NREQ - 1);
            cnt_q        <= '0;
            sended_q     <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            tmo_q        <= 1'b0;
            en_q         <= 1'b0;
            trig_q       <= 1'b0;
            odd_q        <= 1'b0;
            stop_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sended_q     <= uart_sended;
            grant_q      <= grant_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            en_q         <= en_d;
            trig_q       <= trig_d;
            odd_q        <= odd_d;
            stop_q       <= stop_d;
            data_q       <= data_d;
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign tmo_err      = tmo_q;
    assign busy         = (state_q != S_IDLE);
    assign uart_enable  = en_q;
    assign uart_trigger = trig_q;
    assign uart_odd     = odd_q;
    assign uart_stop    = stop_q;
    assign uart_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Two schedulers share all stimulus: one with the long default watchdog for
// normal traffic and one with TIMEOUT=100 for the watchdog cases. "sel"
// chooses which instance's outputs are observed. Expected grants, frame
// fields and done vectors are pushed when stimulus is applied and popped when
// the observed instance produces the matching event.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int GAP   = 16;
    localparam int TO_S  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_odd, req_stop;
    logic [31:0] req_data;
    logic        uart_sended;

    logic [3:0]  grant_l, done_l, grant_s, done_s;
    logic        tmo_l, busy_l, en_l, trig_l, odd_l, stop_l;
    logic        tmo_s, busy_s, en_s, trig_s, odd_s, stop_s;
    logic [7:0]  data_l, data_s;

    logic        sel;
    logic [3:0]  grant, done;
    logic        tmo, busy, en, trig, odd, stop;
    logic [7:0]  data;
    logic [21:0] outs;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_now = 0;
    int last;

    logic [3:0] exp_grant_q[$];
    logic [9:0] exp_frame_q[$];
    logic [3:0] exp_done_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(100000), .GAP(GAP), .CW(17)) dut_long (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_odd(req_odd),
        .req_stop(req_stop), .grant(grant_l), .done(done_l), .tmo_err(tmo_l),
        .busy(busy_l), .uart_enable(en_l), .uart_trigger(trig_l), .uart_odd(odd_l),
        .uart_stop(stop_l), .uart_tx_data(data_l), .uart_sended(uart_sended)
    );

    uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TO_S), .GAP(GAP), .CW(17)) dut_short (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_odd(req_odd),
        .req_stop(req_stop), .grant(grant_s), .done(done_s), .tmo_err(tmo_s),
        .busy(busy_s), .uart_enable(en_s), .uart_trigger(trig_s), .uart_odd(odd_s),
        .uart_stop(stop_s), .uart_tx_data(data_s), .uart_sended(uart_sended)
    );

    assign grant = sel ? grant_s : grant_l;
    assign done  = sel ? done_s  : done_l;
    assign tmo   = sel ? tmo_s   : tmo_l;
    assign busy  = sel ? busy_s  : busy_l;
    assign en    = sel ? en_s    : en_l;
    assign trig  = sel ? trig_s  : trig_l;
    assign odd   = sel ? odd_s   : odd_l;
    assign stop  = sel ? stop_s  : stop_l;
    assign data  = sel ? data_s  : data_l;
    assign outs  = {grant, done, tmo, busy, en, trig, odd, stop, data};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc_now++;
        end
    endtask

    // kind 0: grant, 1: trigger, 2: done or tmo_err
    task automatic wait_evt(input int kind, input int budget, input string tag, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            tick(1);
            cyc++;
            case (kind)
                0:       hit = (grant != 4'b0);
                1:       hit = trig;
                default: hit = (done != 4'b0) || tmo;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: no event within %0d cycles", tag, budget);
        end
    endtask

    // Reference round-robin: first set bit after the last winner, wrapping.
    task automatic model_pick(input logic [3:0] r, output logic [3:0] g, output int w);
        int c;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (last + k) % NREQ;
            if (w < 0 && r[c]) w = c;
        end
        if (w >= 0) begin
            last = w;
            g = 4'b0001 << w;
        end else begin
            g = 4'b0000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        last = NREQ - 1;
    endtask

    initial begin
        logic [3:0] g;
        logic [9:0] frame;
        logic [3:0] seen;
        int w, c, n, t_grant, t_prev;

        sel = 1'b0;
        rst = 1'b1;
        req = 4'hF;
        req_data = 32'hDEAD_BEEF;
        req_odd = 4'hF;
        req_stop = 4'hF;
        uart_sended = 1'b0;
        tick(3);
        chk("reset_outs", 32'(outs), 32'h0);
        req = 4'h0;
        req_data = 32'h0;
        req_odd = 4'h0;
        req_stop = 4'h0;
        rst = 1'b0;
        last = NREQ - 1;
        tick(2);
        chk("idle_no_req", 32'(outs), 32'h0);

        // Single request with config isolation after grant
        req_data[15:8] = 8'hA5;
        req_odd[1] = 1'b1;
        req_stop[1] = 1'b0;
        req = 4'b0010;
        model_pick(req, g, w);
        exp_grant_q.push_back(g);
        exp_frame_q.push_back({1'b1, 1'b0, 8'hA5});
        exp_done_q.push_back(g);
        wait_evt(0, 5, "t1_grant_wait", c);
        chk("t1_grant_lat", c, 1);
        chk("t1_grant", grant, exp_grant_q.pop_front());
        t_grant = cyc_now;
        req_data[15:8] = 8'h5A;
        req_odd[1] = 1'b0;
        tick(1);
        chk("t1_grant_pulse", grant, 4'b0);
        chk("t1_busy_en", {busy, en}, 2'b11);
        wait_evt(1, 5, "t1_trig_wait", c);
        chk("t1_trig_lat", cyc_now - t_grant, 2);
        frame = exp_frame_q.pop_front();
        chk("t1_frame", {odd, stop, data}, frame);
        tick(1);
        chk("t1_trig_pulse", trig, 1'b0);
        tick(198);
        uart_sended = 1'b1;
        wait_evt(2, 5, "t1_done_wait", c);
        chk("t1_done_lat", c, 1);
        chk("t1_done", done, exp_done_q.pop_front());
        chk("t1_no_tmo", tmo, 1'b0);
        chk("t1_iso", {odd, stop, data}, frame);
        req = 4'b0;
        tick(1);
        chk("t1_done_pulse", done, 4'b0);
        uart_sended = 1'b0;
        n = 1;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        chk("t1_gap_len", n, GAP);
        chk("t1_en_off", en, 1'b0);
        chk("t1_data_hold", data, 8'hA5);

        // Round robin with all requesters held and a 50-cycle UART
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
        req_odd = 4'b0101;
        req_stop = 4'b0011;
        req = 4'hF;
        t_prev = 0;
        for (int f = 0; f < 5; f++) begin
            model_pick(req, g, w);
            exp_grant_q.push_back(g);
            exp_frame_q.push_back({req_odd[w], req_stop[w], req_data[8*w +: 8]});
            exp_done_q.push_back(g);
            wait_evt(0, 100, "rr_grant_wait", c);
            chk("rr_grant", grant, exp_grant_q.pop_front());
            wait_evt(1, 5, "rr_trig_wait", c);
            chk("rr_frame", {odd, stop, data}, exp_frame_q.pop_front());
            if (f > 0) chk("rr_spacing_ok", 32'(cyc_now - t_prev >= 50 + GAP + 4), 1);
            t_prev = cyc_now;
            tick(50);
            uart_sended = 1'b1;
            wait_evt(2, 5, "rr_done_wait", c);
            chk("rr_done", done, exp_done_q.pop_front());
            tick(1);
            uart_sended = 1'b0;
        end
        req = 4'b0;

        // Watchdog expiry, then next requester, then simultaneous edge
        sel = 1'b1;
        do_reset();
        req = 4'b0011;
        model_pick(req, g, w);
        exp_grant_q.push_back(g);
        wait_evt(0, 5, "to_grant_wait", c);
        chk("to_grant", grant, exp_grant_q.pop_front());
        wait_evt(1, 5, "to_trig_wait", c);
        wait_evt(2, 150, "to_evt_wait", c);
        chk("to_lat", c, TO_S);
        chk("to_tmo", tmo, 1'b1);
        chk("to_no_done", done, 4'b0);
        req = 4'b0010;
        tick(1);
        chk("to_tmo_pulse", tmo, 1'b0);
        model_pick(req, g, w);
        exp_grant_q.push_back(g);
        exp_done_q.push_back(g);
        wait_evt(0, 40, "to_next_wait", c);
        chk("to_next_grant", grant, exp_grant_q.pop_front());
        wait_evt(1, 5, "sim_trig_wait", c);
        tick(99);
        uart_sended = 1'b1;
        wait_evt(2, 5, "sim_evt_wait", c);
        chk("sim_lat", c, 1);
        chk("sim_done", done, exp_done_q.pop_front());
        chk("sim_no_tmo", tmo, 1'b0);
        tick(1);
        uart_sended = 1'b0;
        req = 4'b0;

        // Reset in the middle of WAIT
        sel = 1'b0;
        do_reset();
        req = 4'b0001;
        model_pick(req, g, w);
        exp_grant_q.push_back(g);
        wait_evt(0, 5, "mr_grant_wait", c);
        chk("mr_grant", grant, exp_grant_q.pop_front());
        wait_evt(1, 5, "mr_trig_wait", c);
        tick(10);
        req = 4'b0;
        do_reset();
        chk("mr_outs", 32'(outs), 32'h0);
        uart_sended = 1'b1;
        seen = 4'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen = seen | done;
        end
        chk("mr_no_done", seen, 4'b0);
        uart_sended = 1'b0;
        req = 4'b0011;
        model_pick(req, g, w);
        exp_grant_q.push_back(g);
        wait_evt(0, 5, "mr_regrant_wait", c);
        chk("mr_regrant", grant, exp_grant_q.pop_front());
        req = 4'b0;
        tick(2);

        chk("sb_empty", exp_grant_q.size() + exp_frame_q.size() + exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit path among NREQ requesters using round-robin arbitration.
- Latches the winner's byte, parity and stop configuration, then issues one trigger pulse.
- Waits for the UART's sended completion and reports done, or a timeout, back to that requester.
- Sits between client logic and the uart_module instance; drives its tx_data, trigger, odd_ctrl, stop and enable_ctrl inputs.

Parameters:
- NREQ, 4: number of requesters, range 2..8.
- TIMEOUT, 100000: clock cycles allowed in WAIT before sended must rise.
- GAP, 16: idle cycles enforced after each frame before the next grant, minimum 1.
- CW, 17: counter width; must hold max(TIMEOUT, GAP).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester level request; held until that requester's done or tmo_err.
- req_data  in  8*NREQ  byte for requester i, in bits [8i+7:8i].
- req_odd  in  NREQ  parity select per requester.
- req_stop  in  NREQ  stop-bit select per requester.
- grant  out  NREQ  one-hot, 1-cycle pulse when a requester's byte is latched.
- done  out  NREQ  one-hot, 1-cycle pulse when the frame completes.
- tmo_err  out  1  1-cycle pulse when TIMEOUT expires; it accompanies no done.
- busy  out  1  high in every state except IDLE.
- uart_enable  out  1  UART enable; high from SETUP through GAPW.
- uart_trigger  out  1  1-cycle send strobe to the UART.
- uart_odd  out  1  latched parity select.
- uart_stop  out  1  latched stop select.
- uart_tx_data  out  8  latched byte.
- uart_sended  in  1  UART completion flag; only its rising edge is used.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - state=IDLE; all outputs 0; uart_tx_data=0.
  - last_grant pointer = NREQ-1, so requester 0 has first priority.
  - sended_q=0; counter=0.
  - A reset in any state aborts the frame silently: no done and no tmo_err.
- Edge detect: sended_q registers uart_sended every cycle; sended_rise = uart_sended & ~sended_q.
- IDLE:
  - If req != 0, select the first set bit scanning from last_grant+1 upward, with wrap-around.
  - Registered on that edge: cur ← winner index, last_grant ← winner, uart_tx_data/uart_odd/uart_stop ← the winner's fields.
  - grant[winner]=1 for exactly that one cycle; go to SETUP.
  - With no request, stay in IDLE and drive all strobes low.
- SETUP:
  - One cycle; uart_enable=1 and data/config stable.
  - Guarantees config is valid at least 1 cycle before the trigger. Go to FIRE.
- FIRE:
  - uart_trigger=1 for exactly one cycle; counter←0; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On sended_rise: done[cur]=1 (1 cycle); go to GAPW.
  - Else when counter == TIMEOUT-1: tmo_err=1 (1 cycle); go to GAPW.
  - If both occur in the same cycle, sended_rise wins: done is asserted and tmo_err is not.
  - A sended_rise seen outside WAIT is ignored.
- GAPW:
  - counter←0 on entry; count GAP cycles, then deassert uart_enable and return to IDLE.
  - No grant is issued during GAPW.
- Latency: from req rising in IDLE to grant takes 1 cycle (registered), and grant to uart_trigger takes 2 cycles.
  - From sended_rise to done takes 0 additional cycles: done is the registered output on the edge where sended_rise is sampled.
- Fairness:
  - After requester i is served, the next scan starts at i+1.
  - With all requesters continuously asserting, service order is 0,1,2,3,0,...
- Latched fields:
  - uart_tx_data, uart_odd and uart_stop hold their values until the next grant.
  - Requester input changes after grant do not affect the frame in flight.
- A requester dropping req after grant is allowed; the frame still completes and done still pulses.
- uart_odd and uart_stop are never changed while busy=1.

Test Plan:
- Single request, req=4'b0010, req_data[15:8]=8'hA5, req_odd=1: grant=0010 for 1 cycle; after 2 cycles uart_trigger pulses with uart_tx_data=A5 and uart_odd=1. uart_sended rising 200 cycles later → done=0010 for 1 cycle, then GAP cycles of busy, then IDLE.
- All four requesters held high, with the UART model returning sended 50 cycles after each trigger: grants occur in order 0001,0010,0100,1000,0001. Successive triggers are ≥ 50+GAP+4 cycles apart.
- Timeout with TIMEOUT=100, uart_sended held 0: tmo_err pulses exactly 100 cycles after entering WAIT, with no done; the scheduler then grants the next requester.
- Simultaneous events: sended_rise arrives in the same cycle the counter reaches TIMEOUT-1 → done asserted, tmo_err stays 0.
- Reset mid-frame: rst=1 for 1 cycle while in WAIT → next cycle all outputs 0 and state IDLE. A subsequent sended_rise produces no done, and requester 0 is granted first again.
- Config isolation: change req_data and req_odd of the granted requester 1 cycle after grant → uart_tx_data and uart_odd keep the latched values until done.
